// File: rtl/layer_in.sv
// Frame loader: byte stream to per-layer frame buffer write strobes.
// Define LAYER_IN_RGBW_EN for four channels (G, R, B, W) per pixel.
module layer_in #(
    parameter int LAYER_NUM = 8,
    parameter int PIXEL_NUM = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_start_in,
    input  logic                 byte_rdy_in,
    input  logic [7:0]           byte_data_in,
    output logic [LAYER_NUM-1:0] layer_en_out,
    output logic [5:0]           wr_addr_out,
    output logic [3:0]           byte_en_out,
    output logic [7:0]           byte_data_out,
    output logic                 frame_rdy_out,
    output logic                 frame_ovf_out
);

`ifdef LAYER_IN_RGBW_EN
    localparam int CH = 4;
`else
    localparam int CH = 3;
`endif

    localparam int LW = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;

    localparam logic [1:0]    CH_LAST  = 2'(CH - 1);
    localparam logic [5:0]    PIX_LAST = 6'(PIXEL_NUM - 1);
    localparam logic [LW-1:0] LAY_LAST = LW'(LAYER_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]    r_ch;
    logic [5:0]    r_pix;
    logic [LW-1:0] r_lay;

    logic [1:0]    w_ch_cur;
    logic [5:0]    w_pix_cur;
    logic [LW-1:0] w_lay_cur;

    logic [1:0]    w_ch_nxt;
    logic [5:0]    w_pix_nxt;
    logic [LW-1:0] w_lay_nxt;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_ovf_set;
    logic [LAYER_NUM-1:0] w_lay_oh;
    logic [3:0]           w_ben;

    // A start pulse zeroes the position seen by a coincident byte,
    // so that byte lands as byte 0 of the new frame.
    always_comb begin
        w_ch_cur  = r_ch;
        w_pix_cur = r_pix;
        w_lay_cur = r_lay;
        if (frame_start_in) begin
            w_ch_cur  = '0;
            w_pix_cur = '0;
            w_lay_cur = '0;
        end
    end

    always_comb begin
        w_accept  = byte_rdy_in &&
                    (frame_start_in || (r_state == LOAD));
        w_last    = w_accept &&
                    (w_ch_cur == CH_LAST) &&
                    (w_pix_cur == PIX_LAST) &&
                    (w_lay_cur == LAY_LAST);
        w_ovf_set = byte_rdy_in && !frame_start_in &&
                    (r_state == DONE);
    end

    always_comb begin
        w_ch_nxt  = w_ch_cur;
        w_pix_nxt = w_pix_cur;
        w_lay_nxt = w_lay_cur;
        if (w_accept) begin
            if (w_ch_cur == CH_LAST) begin
                w_ch_nxt = '0;
                if (w_pix_cur == PIX_LAST) begin
                    w_pix_nxt = '0;
                    if (w_lay_cur == LAY_LAST) begin
                        w_lay_nxt = '0;
                    end else begin
                        w_lay_nxt = w_lay_cur + 1'b1;
                    end
                end else begin
                    w_pix_nxt = w_pix_cur + 1'b1;
                end
            end else begin
                w_ch_nxt = w_ch_cur + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (frame_start_in) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (frame_start_in) w_state_nxt = LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Single-byte frames can complete on the start cycle itself.
        if (w_last) w_state_nxt = DONE;
    end

    always_comb begin
        w_lay_oh = '0;
        for (int i = 0; i < LAYER_NUM; i++) begin
            w_lay_oh[i] = (w_lay_cur == LW'(i));
        end
        w_ben = 4'b0001 << w_ch_cur;
`ifndef LAYER_IN_RGBW_EN
        w_ben[3] = 1'b0;
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_pix   <= '0;
            r_lay   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_pix   <= w_pix_nxt;
            r_lay   <= w_lay_nxt;
        end
    end

    // Address and data hold between writes; only the enables drop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            layer_en_out  <= '0;
            wr_addr_out   <= '0;
            byte_en_out   <= '0;
            byte_data_out <= '0;
            frame_rdy_out <= 1'b0;
            frame_ovf_out <= 1'b0;
        end else begin
            layer_en_out  <= w_accept ? w_lay_oh : '0;
            byte_en_out   <= w_accept ? w_ben : 4'b0000;
            frame_rdy_out <= w_last;
            if (w_accept) begin
                wr_addr_out   <= w_pix_cur;
                byte_data_out <= byte_data_in;
            end
            if (frame_start_in) begin
                frame_ovf_out <= 1'b0;
            end else if (w_ovf_set) begin
                frame_ovf_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_in.sv
// Self-checking bench for layer_in: reference model feeds a write
// scoreboard, outputs are checked #1 after every rising edge.
module tb_layer_in;

`ifdef LAYER_IN_RGBW_EN
    localparam int CH = 4;
`else
    localparam int CH = 3;
`endif
    localparam int LN = 8;
    localparam int PN = 64;
    localparam int FRAME = LN * PN * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fs = 1'b0;
    logic          br = 1'b0;
    logic [7:0]    bd = 8'h00;
    logic [LN-1:0] layer_en;
    logic [5:0]    addr;
    logic [3:0]    ben;
    logic [7:0]    data;
    logic          rdy;
    logic          ovf;

    layer_in #(.LAYER_NUM(LN), .PIXEL_NUM(PN)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .frame_start_in(fs),
        .byte_rdy_in   (br),
        .byte_data_in  (bd),
        .layer_en_out  (layer_en),
        .wr_addr_out   (addr),
        .byte_en_out   (ben),
        .byte_data_out (data),
        .frame_rdy_out (rdy),
        .frame_ovf_out (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] len;
        logic [5:0] addr;
        logic [3:0] ben;
        logic [7:0] data;
        logic       rdy;
    } wr_t;

    wr_t sb[$];
    int  passed = 0;
    int  total = 0;
    int  rdy_cnt = 0;
    bit  m_open = 0;
    bit  m_done = 0;
    bit  m_ovf = 0;
    int  m_idx = 0;
    logic [5:0] m_addr = '0;
    logic [7:0] m_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model(input logic s, input logic r,
                         input logic [7:0] d);
        wr_t e;
        if (s) begin
            m_open = 1;
            m_done = 0;
            m_ovf  = 0;
            m_idx  = 0;
        end
        if (r) begin
            if (m_open) begin
                e.len  = 8'(1 << (m_idx / (CH * PN)));
                e.addr = 6'((m_idx / CH) % PN);
                e.ben  = 4'(1 << (m_idx % CH));
                e.data = d;
                e.rdy  = (m_idx == FRAME - 1);
                sb.push_back(e);
                m_idx++;
                if (m_idx == FRAME) begin
                    m_open = 0;
                    m_done = 1;
                end
            end else if (m_done) begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_out();
        wr_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("layer_en", 32'(layer_en), 32'(e.len));
            chk("wr_addr", 32'(addr), 32'(e.addr));
            chk("byte_en", 32'(ben), 32'(e.ben));
            chk("data", 32'(data), 32'(e.data));
            chk("frame_rdy", 32'(rdy), 32'(e.rdy));
            m_addr = e.addr;
            m_data = e.data;
        end else begin
            chk("idle_layer_en", 32'(layer_en), 32'd0);
            chk("idle_byte_en", 32'(ben), 32'd0);
            chk("idle_rdy", 32'(rdy), 32'd0);
            chk("hold_addr", 32'(addr), 32'(m_addr));
            chk("hold_data", 32'(data), 32'(m_data));
        end
        chk("frame_ovf", 32'(ovf), 32'(m_ovf));
        if (rdy === 1'b1) rdy_cnt++;
    endtask

    task automatic step(input logic s, input logic r,
                        input logic [7:0] d);
        @(negedge clk);
        fs = s;
        br = r;
        bd = d;
        model(s, r, d);
        @(posedge clk);
        #1;
        fs = 1'b0;
        br = 1'b0;
        check_out();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_layer_en"}, 32'(layer_en), 32'd0);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_byte_en"}, 32'(ben), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_rdy"}, 32'(rdy), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        fs = 1'b0;
        br = 1'b0;
        #1;
        check_zero(tag);
        m_open = 0;
        m_done = 0;
        m_ovf  = 0;
        m_idx  = 0;
        m_addr = '0;
        m_data = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset("reset");

        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 8'(k));

        rdy_cnt = 0;
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, 1'b1, 8'(k));
`ifdef LAYER_IN_RGBW_EN
            if (k == 3) begin
                chk("b3_len", 32'(layer_en), 32'h01);
                chk("b3_addr", 32'(addr), 32'd0);
                chk("b3_ben", 32'(ben), 32'h8);
            end
            if (k == FRAME - 1) chk("last_ben", 32'(ben), 32'h8);
`else
            if (k == 3) begin
                chk("b3_len", 32'(layer_en), 32'h01);
                chk("b3_addr", 32'(addr), 32'd1);
                chk("b3_ben", 32'(ben), 32'h1);
                chk("b3_data", 32'(data), 32'h03);
            end
            if (k == 192) begin
                chk("b192_len", 32'(layer_en), 32'h02);
                chk("b192_addr", 32'(addr), 32'd0);
            end
            if (k == FRAME - 1) chk("last_ben", 32'(ben), 32'h4);
`endif
            if (k == FRAME - 1) begin
                chk("last_len", 32'(layer_en), 32'h80);
                chk("last_addr", 32'(addr), 32'd63);
                chk("last_rdy", 32'(rdy), 32'd1);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        chk("f1_rdy_cnt", 32'(rdy_cnt), 32'd1);

        rdy_cnt = 0;
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 100; k++) step(1'b0, 1'b1, 8'(k + 7));
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            if (k == 0) begin
                chk("restart_len", 32'(layer_en), 32'h01);
                chk("restart_addr", 32'(addr), 32'd0);
                chk("restart_ben", 32'(ben), 32'h1);
            end
        end
        chk("f2_rdy_cnt", 32'(rdy_cnt), 32'd1);

        rdy_cnt = 0;
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < FRAME + 4; k++) step(1'b0, 1'b1, 8'(k));
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00);
        chk("ovf_rdy_cnt", 32'(rdy_cnt), 32'd1);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        step(1'b1, 1'b1, 8'hAA);
        chk("coin_len", 32'(layer_en), 32'h01);
        chk("coin_addr", 32'(addr), 32'd0);
        chk("coin_ben", 32'(ben), 32'h1);
        chk("coin_data", 32'(data), 32'hAA);
        chk("coin_ovf", 32'(ovf), 32'd0);

        rdy_cnt = 0;
        for (int k = 1; k < 1000; k++) step(1'b0, 1'b1, 8'(k));
        do_reset("midrst");
        chk("midrst_rdy_cnt", 32'(rdy_cnt), 32'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 8'(k));
        chk("post_rst_rdy_cnt", 32'(rdy_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
